// File: rtl/dmem_sync_handshake.sv
// Clocked byte-addressed data memory with valid/ready request, wait states and error response.
// Optional build macro: DMEM_MISALIGN_CHECK_EN rejects misaligned halfword/word accesses.
module dmem_sync_handshake #(
  parameter int unsigned DEPTH_BYTES = 512,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReadWrite,
  input  logic                  SignExt,
  input  logic [1:0]            Size,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic [31:0]           DataIn,
  output logic                  RespValid,
  output logic [31:0]           DataOut,
  output logic                  Error,
  output logic                  Busy
);

  localparam int unsigned IDX_W = $clog2(DEPTH_BYTES);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                r_state, w_state_next;
  logic [3:0]            r_cnt, w_cnt_next;
  logic                  r_rw, r_sext, r_err;
  logic [1:0]            r_size;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [31:0]           r_din, r_dout;
  logic [7:0]            r_mem [DEPTH_BYTES];

  logic                  w_accept, w_access, w_err, w_oob, w_misalign;
  logic [ADDR_WIDTH:0]   w_nbytes_m1, w_last;
  logic [IDX_W-1:0]      w_idx0, w_idx1, w_idx2, w_idx3;
  logic [7:0]            w_b0, w_b1, w_b2, w_b3;
  logic [31:0]           w_load;

  assign ReqReady  = (r_state == StIdle) && !Reset;
  assign Busy      = (r_state != StIdle) && !Reset;
  assign RespValid = (r_state == StResp) && !Reset;
  assign Error     = RespValid && r_err;
  assign DataOut   = r_dout;

  assign w_accept = ReqValid && ReqReady;
  assign w_access = (r_state == StWait) && (r_cnt == 4'd0);

  // Extra top bit keeps the end-address compare free of wrap-around.
  always_comb begin
    w_nbytes_m1 = '0;
    case (r_size)
      2'b00:   w_nbytes_m1 = (ADDR_WIDTH+1)'(0);
      2'b01:   w_nbytes_m1 = (ADDR_WIDTH+1)'(1);
      default: w_nbytes_m1 = (ADDR_WIDTH+1)'(3);
    endcase
  end

  assign w_last = {1'b0, r_addr} + w_nbytes_m1;
  assign w_oob  = w_last >= (ADDR_WIDTH+1)'(DEPTH_BYTES);

`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_misalign = ((r_size == 2'b01) && r_addr[0]) ||
                      ((r_size == 2'b10) && (r_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_err = (r_size == 2'b11) || w_oob || w_misalign;

  assign w_idx0 = r_addr[IDX_W-1:0];
  assign w_idx1 = w_idx0 + IDX_W'(1);
  assign w_idx2 = w_idx0 + IDX_W'(2);
  assign w_idx3 = w_idx0 + IDX_W'(3);
  assign w_b0   = r_mem[w_idx0];
  assign w_b1   = r_mem[w_idx1];
  assign w_b2   = r_mem[w_idx2];
  assign w_b3   = r_mem[w_idx3];

  always_comb begin
    w_load = '0;
    case (r_size)
      2'b00:   w_load = {{24{r_sext & w_b0[7]}}, w_b0};
      2'b01:   w_load = {{16{r_sext & w_b0[7]}}, w_b0, w_b1};
      2'b10:   w_load = {w_b0, w_b1, w_b2, w_b3};
      default: w_load = '0;
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_next = StWait;
          w_cnt_next   = 4'(WAIT_STATES);
        end
      end
      StWait: begin
        if (r_cnt != 4'd0) w_cnt_next = r_cnt - 4'd1;
        else               w_state_next = StResp;
      end
      StResp:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_rw    <= 1'b0;
      r_sext  <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= '0;
      r_din   <= '0;
      r_dout  <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_rw   <= ReadWrite;
        r_sext <= SignExt;
        r_size <= Size;
        r_addr <= Address;
        r_din  <= DataIn;
      end
      if (w_access) begin
        r_err <= w_err;
        if (!r_rw) r_dout <= w_err ? 32'd0 : w_load;
      end
    end
  end

  // Array is not reset; a reset on the access edge suppresses the write.
  always_ff @(posedge Clk) begin
    if (!Reset && w_access && r_rw && !w_err) begin
      case (r_size)
        2'b00: r_mem[w_idx0] <= r_din[7:0];
        2'b01: begin
          r_mem[w_idx0] <= r_din[15:8];
          r_mem[w_idx1] <= r_din[7:0];
        end
        2'b10: begin
          r_mem[w_idx0] <= r_din[31:24];
          r_mem[w_idx1] <= r_din[23:16];
          r_mem[w_idx2] <= r_din[15:8];
          r_mem[w_idx3] <= r_din[7:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_sync_handshake.sv
// Randomized self-checking bench for dmem_sync_handshake against a byte-array reference model.
module tb_dmem_sync_handshake;

  localparam int unsigned DEPTH = 512;
  localparam int unsigned AW    = 32;
  localparam int unsigned WS    = 1;

  logic          Clk = 1'b0;
  logic          Reset, ReqValid, ReqReady, ReadWrite, SignExt;
  logic [1:0]    Size;
  logic [AW-1:0] Address;
  logic [31:0]   DataIn, DataOut;
  logic          RespValid, Error, Busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  m [DEPTH];
  logic [31:0] exp_dout = 32'd0;
  bit          q_err [$];
  logic [31:0] q_dout [$];

  dmem_sync_handshake #(
    .DEPTH_BYTES(DEPTH),
    .ADDR_WIDTH (AW),
    .WAIT_STATES(WS)
  ) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .ReqValid (ReqValid),
    .ReqReady (ReqReady),
    .ReadWrite(ReadWrite),
    .SignExt  (SignExt),
    .Size     (Size),
    .Address  (Address),
    .DataIn   (DataIn),
    .RespValid(RespValid),
    .DataOut  (DataOut),
    .Error    (Error),
    .Busy     (Busy)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Applies one access to the model; returns the expected error flag.
  function automatic bit model(input bit rw, input bit sext, input logic [1:0] sz,
                               input logic [31:0] addr, input logic [31:0] din);
    int    n;
    bit    err;
    longint unsigned val;
    n   = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    err = (sz == 2'd3) || (longint'(addr) + n - 1 >= longint'(DEPTH));
`ifdef DMEM_MISALIGN_CHECK_EN
    if ((sz == 2'd1 && addr % 2 != 0) || (sz == 2'd2 && addr % 4 != 0)) err = 1'b1;
`endif
    if (err) begin
      if (!rw) exp_dout = 32'd0;
    end else if (rw) begin
      for (int i = 0; i < n; i++) m[addr + i] = 8'(din >> (8 * (n - 1 - i)));
    end else begin
      val = 0;
      for (int i = 0; i < n; i++) val = (val << 8) | longint'(m[addr + i]);
      if (sext && n < 4 && val[8*n-1]) val = val | (~64'd0 << (8 * n));
      exp_dout = 32'(val);
    end
    return err;
  endfunction

  task automatic scramble();
    ReadWrite = 1'($urandom);
    SignExt   = 1'($urandom);
    Size      = 2'($urandom);
    Address   = $urandom;
    DataIn    = $urandom;
  endtask

  task automatic rand_req();
    int sel;
    sel       = $urandom_range(0, 9);
    ReadWrite = 1'($urandom);
    SignExt   = 1'($urandom);
    Size      = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
    DataIn    = $urandom;
    if (sel < 7)       Address = $urandom_range(0, DEPTH - 1);
    else if (sel < 9)  Address = $urandom_range(DEPTH - 4, DEPTH + 3);
    else               Address = $urandom;
  endtask

  task automatic do_req(input bit rw, input bit sext, input logic [1:0] sz,
                        input logic [31:0] addr, input logic [31:0] din);
    bit e, bad;
    int n;
    @(negedge Clk);
    ReqValid = 1'b1; ReadWrite = rw; SignExt = sext; Size = sz; Address = addr; DataIn = din;
    n = 0;
    while (!ReqReady && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (!ReqReady) begin
      check_eq("accept_timeout", 32'd0, 32'd1);
      ReqValid = 1'b0;
      return;
    end
    e = model(rw, sext, sz, addr, din);
    @(posedge Clk);
    #1;
    ReqValid = 1'b0;
    scramble();
    n   = 0;
    bad = 1'b0;
    do begin
      @(negedge Clk);
      n++;
      if (!RespValid && (ReqReady || !Busy)) bad = 1'b1;
    end while (!RespValid && n < 50);
    check_eq("resp_latency", n, WS + 2);
    check_eq("ready_busy_in_flight", 32'(bad), 32'd0);
    check_eq("error", 32'(Error), 32'(e));
    check_eq("dataout", DataOut, exp_dout);
    @(negedge Clk);
    check_eq("resp_pulse_width", 32'(RespValid), 32'd0);
  endtask

  // ReqValid held high: back-to-back requests, responses checked in order.
  task automatic stream(input int count);
    int  acc, resp, cyc, last_acc;
    bit  e;
    acc = 0; resp = 0; cyc = 0; last_acc = -1;
    @(negedge Clk);
    rand_req();
    ReqValid = 1'b1;
    while ((acc < count || resp < acc) && cyc < 4000) begin
      cyc++;
      if (RespValid) begin
        resp++;
        if (q_err.size() == 0) begin
          check_eq("stream_extra_resp", 32'd1, 32'd0);
        end else begin
          check_eq("stream_error", 32'(Error), 32'(q_err.pop_front()));
          check_eq("stream_dataout", DataOut, q_dout.pop_front());
        end
      end
      if (ReqReady && ReqValid) begin
        e = model(ReadWrite, SignExt, Size, Address, DataIn);
        q_err.push_back(e);
        q_dout.push_back(exp_dout);
        if (last_acc >= 0) check_eq("stream_spacing", cyc - last_acc, WS + 3);
        last_acc = cyc;
        acc++;
        @(posedge Clk);
        #1;
        rand_req();
        if (acc == count) ReqValid = 1'b0;
      end
      @(negedge Clk);
    end
    check_eq("stream_resp_count", resp, count);
    check_eq("stream_queue_empty", q_err.size(), 0);
  endtask

  initial begin
    Reset = 1'b1; ReqValid = 1'b0;
    scramble();
    repeat (3) @(negedge Clk);
    check_eq("rst_ready", 32'(ReqReady), 32'd0);
    check_eq("rst_resp", 32'(RespValid), 32'd0);
    check_eq("rst_busy", 32'(Busy), 32'd0);
    check_eq("rst_error", 32'(Error), 32'd0);
    check_eq("rst_dout", DataOut, 32'd0);
    Reset = 1'b0;
    @(negedge Clk);
    check_eq("post_rst_ready", 32'(ReqReady), 32'd1);
    check_eq("post_rst_busy", 32'(Busy), 32'd0);

    for (int a = 0; a < DEPTH; a += 4) do_req(1'b1, 1'b0, 2'd2, a, $urandom);

    do_req(1'b1, 1'b0, 2'd2, 32'h10, 32'hDEADBEEF);
    do_req(1'b0, 1'b0, 2'd2, 32'h10, 32'h0);
    check_eq("word_deadbeef", DataOut, 32'hDEADBEEF);
    do_req(1'b0, 1'b1, 2'd0, 32'h12, 32'h0);
    check_eq("lb_signed", DataOut, 32'hFFFFFFBE);
    do_req(1'b0, 1'b0, 2'd0, 32'h12, 32'h0);
    check_eq("lb_unsigned", DataOut, 32'h000000BE);
    do_req(1'b0, 1'b1, 2'd1, 32'h10, 32'h0);
    check_eq("lh_signed", DataOut, 32'hFFFFDEAD);
    do_req(1'b1, 1'b0, 2'd1, 32'h20, 32'h12345678);
    do_req(1'b0, 1'b0, 2'd2, 32'h20, 32'h0);
    check_eq("sh_then_lw_hi", DataOut >> 16, 32'h5678);

    do_req(1'b0, 1'b0, 2'd2, DEPTH - 2, 32'h0);
    check_eq("oob_load_zero", DataOut, 32'h0);
    do_req(1'b1, 1'b0, 2'd2, 32'h1FF, 32'hCAFEF00D);
    do_req(1'b0, 1'b0, 2'd3, 32'h40, 32'h0);
    do_req(1'b1, 1'b0, 2'd3, 32'h40, 32'h11223344);
    do_req(1'b0, 1'b0, 2'd0, 32'h1FF, 32'h0);
    do_req(1'b0, 1'b0, 2'd2, 32'h40, 32'h0);
    do_req(1'b1, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'h55);
    do_req(1'b0, 1'b0, 2'd2, 32'h11, 32'h0);

    // Reset lands on the access edge of a word store to 0x30.
    @(negedge Clk);
    ReqValid = 1'b1; ReadWrite = 1'b1; SignExt = 1'b0; Size = 2'd2;
    Address = 32'h30; DataIn = ~{m[32'h30], m[32'h31], m[32'h32], m[32'h33]};
    @(posedge Clk);
    #1;
    ReqValid = 1'b0;
    repeat (WS + 1) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    check_eq("mid_rst_resp", 32'(RespValid), 32'd0);
    check_eq("mid_rst_busy", 32'(Busy), 32'd0);
    check_eq("mid_rst_dout", DataOut, 32'd0);
    exp_dout = 32'd0;
    Reset = 1'b0;
    begin
      int seen;
      seen = 0;
      repeat (6) begin
        @(negedge Clk);
        if (RespValid) seen++;
      end
      check_eq("mid_rst_no_resp", seen, 0);
    end
    do_req(1'b0, 1'b0, 2'd2, 32'h30, 32'h0);

    for (int i = 0; i < 150; i++) begin
      @(negedge Clk);
      rand_req();
      do_req(ReadWrite, SignExt, Size, Address, DataIn);
    end
    stream(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0x%08h expected 0x%08h", 0, 1);
    $fatal(1, "timeout");
  end

endmodule
